// File: rtl/mdu_pkg.sv
// mdu_pkg
// Shared definitions for the multiply/divide unit:
//   - operation encodings (MDU_MUL / MDU_DIV)
//   - FSM state enum
//   - operand width and iteration-counter width
package mdu_pkg;

    localparam int MDU_DATA_WIDTH = 32;
    localparam int MDU_CNT_W      = $clog2(MDU_DATA_WIDTH);

    localparam logic MDU_MUL = 1'b0;
    localparam logic MDU_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } mduState_e;

endpackage

// File: rtl/mdu_addsub.sv
// mdu_addsub
// Combinational adder/subtractor.
// The multiply/divide unit shares one instance between two uses:
//   - the Booth add/subtract step
//   - the restoring-divide trial subtraction
// Ports:
//   a_i     : first operand
//   b_i     : second operand
//   sub_i   : 1 selects a_i - b_i, 0 selects a_i + b_i
//   sum_o   : result, truncated to WIDTH bits
//   carry_o : carry out. When subtracting, 1 means a_i >= b_i (unsigned).
module mdu_addsub
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_DATA_WIDTH + 1
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    logic [WIDTH-1:0] bOperand;

    // Subtraction is done as two's complement: invert b, then inject the +1 as carry-in.
    always_comb begin
        bOperand         = sub_i ? ~b_i : b_i;
        {carry_o, sum_o} = {1'b0, a_i} + {1'b0, bOperand} + {{WIDTH{1'b0}}, sub_i};
    end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit
// Sequential signed multiply/divide unit feeding the HI/LO registers.
//   - Multiply: radix-2 Booth.
//   - Divide: restoring division on operand magnitudes, followed by a sign fix.
//   - Both operations take DATA_WIDTH RUN cycles plus one FIX cycle.
// Ports:
//   clock       : rising-edge clock
//   clear       : asynchronous active-high reset
//   start       : request, sampled only in IDLE or DONE
//   op          : 0 = signed multiply, 1 = signed divide
//   a, b        : multiplicand/dividend and multiplier/divisor
//   busy        : operation in progress
//   done        : one-cycle completion pulse
//   hi_lo_write : copy of done, drives the HI/LO register enables
//   div_zero    : last divide had b == 0
//   hi_out      : product[63:32] or remainder
//   lo_out      : product[31:0] or quotient
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = MDU_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic                  hi_lo_write,
    output logic                  div_zero,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out
);

    localparam int W = DATA_WIDTH;

    mduState_e            state_q;
    logic [MDU_CNT_W-1:0] stepCount_q;
    logic                 op_q;
    logic                 aNeg_q;
    logic                 bNeg_q;
    logic                 bZero_q;
    logic [W:0]           acc_q;
    logic [W-1:0]         low_q;
    logic                 qm1_q;
    logic [W:0]           bOp_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 divZero_q;
    logic [W-1:0]         hi_q;
    logic [W-1:0]         lo_q;

    logic [W:0]   acc_d;
    logic [W-1:0] low_d;
    logic         qm1_d;
    logic [W-1:0] absA;
    logic [W-1:0] absB;
    logic [1:0]   boothPair;
    logic [W:0]   divShift;
    logic [W:0]   boothSel;
    logic [W:0]   addA;
    logic         addSub;
    logic [W:0]   addSum;
    logic         addCarry;
    logic [W-1:0] fixHi;
    logic [W-1:0] fixLo;

    mdu_addsub #(.WIDTH(W + 1)) u_addsub (
        .a_i     (addA),
        .b_i     (bOp_q),
        .sub_i   (addSub),
        .sum_o   (addSum),
        .carry_o (addCarry)
    );

    // One iteration step, plus the final sign fix.
    //   acc_q holds:
    //     - multiply: the Booth accumulator
    //     - divide:   the partial remainder
    //   low_q holds:
    //     - multiply: the multiplier
    //     - divide:   the dividend as it shifts out and the quotient as it shifts in
    // Note: -0x80000000 is 0x80000000 again, which is the correct unsigned magnitude.
    always_comb begin
        absA      = a[W-1] ? -a : a;
        absB      = b[W-1] ? -b : b;
        boothPair = {low_q[0], qm1_q};
        divShift  = {acc_q[W-1:0], low_q[W-1]};
        boothSel  = acc_q;
        acc_d     = acc_q;
        low_d     = low_q;
        qm1_d     = 1'b0;

        if (op_q == MDU_DIV) begin
            addA   = divShift;
            addSub = 1'b1;
            if (addCarry) begin
                acc_d = addSum;
                low_d = {low_q[W-2:0], 1'b1};
            end else begin
                acc_d = divShift;
                low_d = {low_q[W-2:0], 1'b0};
            end
        end else begin
            addA   = acc_q;
            addSub = (boothPair == 2'b10);
            if (boothPair == 2'b01 || boothPair == 2'b10) begin
                boothSel = addSum;
            end
            acc_d = {boothSel[W], boothSel[W:1]};
            low_d = {boothSel[0], low_q[W-1:1]};
            qm1_d = low_q[0];
        end

        // Divide result:
        //   - quotient truncates toward zero
        //   - remainder follows the dividend's sign
        //   - for divide-by-zero the remainder path already reproduces a,
        //     so only the quotient needs forcing to all ones
        if (op_q == MDU_DIV) begin
            fixHi = aNeg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
            if (bZero_q) begin
                fixLo = '1;
            end else begin
                fixLo = (aNeg_q ^ bNeg_q) ? -low_q : low_q;
            end
        end else begin
            fixHi = acc_q[W-1:0];
            fixLo = low_q;
        end
    end

    // Control FSM and datapath registers.
    // Results move to hi_q/lo_q only on the FIX -> DONE transition.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q     <= IDLE;
            stepCount_q <= '0;
            op_q        <= MDU_MUL;
            aNeg_q      <= 1'b0;
            bNeg_q      <= 1'b0;
            bZero_q     <= 1'b0;
            acc_q       <= '0;
            low_q       <= '0;
            qm1_q       <= 1'b0;
            bOp_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            divZero_q   <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q     <= RUN;
                        busy_q      <= 1'b1;
                        stepCount_q <= '0;
                        divZero_q   <= 1'b0;
                        op_q        <= op;
                        aNeg_q      <= a[W-1];
                        bNeg_q      <= b[W-1];
                        bZero_q     <= (b == '0);
                        acc_q       <= '0;
                        qm1_q       <= 1'b0;
                        if (op == MDU_DIV) begin
                            low_q <= absA;
                            bOp_q <= {1'b0, absB};
                        end else begin
                            low_q <= a;
                            bOp_q <= {b[W-1], b};
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_q       <= acc_d;
                    low_q       <= low_d;
                    qm1_q       <= qm1_d;
                    stepCount_q <= stepCount_q + MDU_CNT_W'(1);
                    if (stepCount_q == MDU_CNT_W'(W - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    hi_q      <= fixHi;
                    lo_q      <= fixLo;
                    divZero_q <= (op_q == MDU_DIV) && bZero_q;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    state_q   <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi_lo_write = done_q;
    assign div_zero    = divZero_q;
    assign hi_out      = hi_q;
    assign lo_out      = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit
// Self-checking bench for mul_div_unit.
// Results are compared against a 64-bit integer arithmetic reference model.
module tb_mul_div_unit;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        hi_lo_write;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int checks = 0;
    int errors = 0;

    mul_div_unit dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi_lo_write (hi_lo_write),
        .div_zero    (div_zero),
        .hi_out      (hi_out),
        .lo_out      (lo_out)
    );

    always #5 clock = ~clock;

    // Returns {div_zero, hi, lo} computed with plain signed integer arithmetic.
    function automatic logic [64:0] refMdu(input logic opIn, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      p;
        longint      q;
        longint      r;
        logic [63:0] pv;
        logic [63:0] qv;
        logic [63:0] rv;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (opIn == 1'b0) begin
            p  = sx * sy;
            pv = p;
            return {1'b0, pv};
        end
        if (y == 32'd0) begin
            return {1'b1, x, 32'hFFFF_FFFF};
        end
        q  = sx / sy;
        r  = sx % sy;
        qv = q;
        rv = r;
        return {1'b0, rv[31:0], qv[31:0]};
    endfunction

    // Launches one operation and scrambles the operand inputs right after acceptance.
    // Returns:
    //   - the result observed in the done cycle
    //   - the number of cycles from the start edge to done (-1 on timeout)
    //   - whether busy/hi_lo_write behaved correctly throughout
    task automatic doOp(input logic opIn, input logic [31:0] aIn, input logic [31:0] bIn,
                        output logic [31:0] hiObs, output logic [31:0] loObs, output logic dzObs,
                        output int doneEdge, output logic timingOk);
        @(negedge clock);
        op    = opIn;
        a     = aIn;
        b     = bIn;
        start = 1'b1;
        @(negedge clock);
        start    = 1'b0;
        op       = ~opIn;
        a        = $urandom;
        b        = $urandom;
        doneEdge = -1;
        timingOk = 1'b1;
        hiObs    = '0;
        loObs    = '0;
        dzObs    = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) begin
                doneEdge = k;
                hiObs    = hi_out;
                loObs    = lo_out;
                dzObs    = div_zero;
                if (busy !== 1'b0 || hi_lo_write !== 1'b1) timingOk = 1'b0;
                break;
            end
            if (busy !== 1'b1 || hi_lo_write !== 1'b0) timingOk = 1'b0;
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        clear = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        #3;
        checks++;
        if ({busy, done, hi_lo_write, div_zero} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags got %b expected 0000", {busy, done, hi_lo_write, div_zero});
        end
        checks++;
        if ({hi_out, lo_out} !== 64'd0) begin
            errors++;
            $display("[TB] FAIL reset_data got %h expected 0", {hi_out, lo_out});
        end
        @(negedge clock);
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic test_multiply();
        logic [31:0] dA[3]  = '{32'd7, 32'h7FFF_FFFF, 32'h8000_0000};
        logic [31:0] dB[3]  = '{32'hFFFF_FFFD, 32'h7FFF_FFFF, 32'h8000_0000};
        logic [63:0] dHL[3] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h3FFF_FFFF_0000_0001, 64'h4000_0000_0000_0000};
        logic [31:0] hiObs;
        logic [31:0] loObs;
        logic        dzObs;
        int          edgeObs;
        logic        tOk;
        logic [64:0] exp;
        logic [31:0] x;
        logic [31:0] y;
        for (int i = 0; i < 3; i++) begin
            doOp(1'b0, dA[i], dB[i], hiObs, loObs, dzObs, edgeObs, tOk);
            checks++;
            if (edgeObs !== 33 || tOk !== 1'b1) begin
                errors++;
                $display("[TB] FAIL mul_latency got %0d/%b expected 33/1", edgeObs, tOk);
            end
            checks++;
            if ({hiObs, loObs} !== dHL[i]) begin
                errors++;
                $display("[TB] FAIL mul_directed got %h expected %h", {hiObs, loObs}, dHL[i]);
            end
            @(negedge clock);
            checks++;
            if (done !== 1'b0 || hi_lo_write !== 1'b0 || {hi_out, lo_out} !== dHL[i]) begin
                errors++;
                $display("[TB] FAIL mul_pulse_hold got done=%b wr=%b %h expected 0 0 %h", done, hi_lo_write, {hi_out, lo_out}, dHL[i]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            x   = $urandom;
            y   = $urandom;
            exp = refMdu(1'b0, x, y);
            doOp(1'b0, x, y, hiObs, loObs, dzObs, edgeObs, tOk);
            checks++;
            if ({dzObs, hiObs, loObs} !== exp || edgeObs !== 33 || tOk !== 1'b1) begin
                errors++;
                $display("[TB] FAIL mul_random %h*%h got %h@%0d expected %h@33", x, y, {dzObs, hiObs, loObs}, edgeObs, exp);
            end
        end
    endtask

    task automatic test_divide();
        logic [31:0] dA[3]  = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000};
        logic [31:0] dB[3]  = '{32'd2, 32'd7, 32'hFFFF_FFFF};
        logic [63:0] dHL[3] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0002_0000_000E, 64'h0000_0000_8000_0000};
        logic [31:0] hiObs;
        logic [31:0] loObs;
        logic        dzObs;
        int          edgeObs;
        logic        tOk;
        logic [64:0] exp;
        logic [31:0] x;
        logic [31:0] y;
        for (int i = 0; i < 3; i++) begin
            doOp(1'b1, dA[i], dB[i], hiObs, loObs, dzObs, edgeObs, tOk);
            checks++;
            if ({dzObs, hiObs, loObs} !== {1'b0, dHL[i]} || edgeObs !== 33 || tOk !== 1'b1) begin
                errors++;
                $display("[TB] FAIL div_directed got %h@%0d expected %h@33", {dzObs, hiObs, loObs}, edgeObs, {1'b0, dHL[i]});
            end
        end
        for (int i = 0; i < 16; i++) begin
            x = $urandom;
            y = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) y = -y;
            exp = refMdu(1'b1, x, y);
            doOp(1'b1, x, y, hiObs, loObs, dzObs, edgeObs, tOk);
            checks++;
            if ({dzObs, hiObs, loObs} !== exp || edgeObs !== 33 || tOk !== 1'b1) begin
                errors++;
                $display("[TB] FAIL div_random %h/%h got %h@%0d expected %h@33", x, y, {dzObs, hiObs, loObs}, edgeObs, exp);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] hiObs;
        logic [31:0] loObs;
        logic        dzObs;
        int          edgeObs;
        logic        tOk;
        doOp(1'b1, 32'd5, 32'd0, hiObs, loObs, dzObs, edgeObs, tOk);
        checks++;
        if ({dzObs, hiObs, loObs} !== {1'b1, 32'd5, 32'hFFFF_FFFF} || edgeObs !== 33) begin
            errors++;
            $display("[TB] FAIL div_zero_pos got %h@%0d expected 1_00000005_ffffffff@33", {dzObs, hiObs, loObs}, edgeObs);
        end
        doOp(1'b1, 32'hFFFF_FFFB, 32'd0, hiObs, loObs, dzObs, edgeObs, tOk);
        checks++;
        if ({dzObs, hiObs, loObs} !== {1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF}) begin
            errors++;
            $display("[TB] FAIL div_zero_neg got %h expected 1_fffffffb_ffffffff", {dzObs, hiObs, loObs});
        end
        // div_zero must stay held through idle cycles and drop at the next accepted start.
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (div_zero !== 1'b1) begin
            errors++;
            $display("[TB] FAIL div_zero_hold got %b expected 1", div_zero);
        end
        op    = 1'b1;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if (div_zero !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL div_zero_clear got dz=%b busy=%b expected 0 1", div_zero, busy);
        end
        for (int k = 0; k < 40 && done !== 1'b1; k++) @(negedge clock);
        checks++;
        if ({done, div_zero, hi_out, lo_out} !== {2'b10, 32'd2, 32'd14}) begin
            errors++;
            $display("[TB] FAIL div_after_zero got %h expected 2_00000002_0000000e", {done, div_zero, hi_out, lo_out});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a0;
        logic [31:0] b0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [64:0] exp0;
        logic [64:0] exp1;
        int          doneEdge;
        int          pulses;
        a0   = $urandom;
        b0   = $urandom;
        a1   = $urandom;
        b1   = ($urandom >> 8) | 32'd1;
        exp0 = refMdu(1'b0, a0, b0);
        exp1 = refMdu(1'b1, a1, b1);
        @(negedge clock);
        op    = 1'b0;
        a     = a0;
        b     = b0;
        start = 1'b1;
        @(negedge clock);
        doneEdge = -1;
        pulses   = 0;
        for (int k = 0; k < 40; k++) begin
            if (k == 10) begin
                op = 1'b1;
                a  = a1;
                b  = b1;
            end
            if (done === 1'b1) begin
                doneEdge = k;
                break;
            end
            @(negedge clock);
        end
        checks++;
        if (doneEdge !== 33 || {div_zero, hi_out, lo_out} !== exp0) begin
            errors++;
            $display("[TB] FAIL hold_start_first got %h@%0d expected %h@33", {div_zero, hi_out, lo_out}, doneEdge, exp0);
        end
        @(negedge clock);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_no_gap got busy=%b done=%b expected 1 0", busy, done);
        end
        doneEdge = -1;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) begin
                doneEdge = k;
                break;
            end
            @(negedge clock);
        end
        checks++;
        if (doneEdge !== 33 || {div_zero, hi_out, lo_out} !== exp1) begin
            errors++;
            $display("[TB] FAIL b2b_second got %h@%0d expected %h@33", {div_zero, hi_out, lo_out}, doneEdge, exp1);
        end
        // Exactly one completion pulse per operation.
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("[TB] FAIL b2b_extra_done got %0d expected 0", pulses);
        end
    endtask

    task automatic test_clear_mid_run();
        logic [31:0] hiObs;
        logic [31:0] loObs;
        logic        dzObs;
        int          edgeObs;
        logic        tOk;
        logic [31:0] x;
        logic [31:0] y;
        logic [64:0] exp;
        doOp(1'b0, 32'd7, 32'hFFFF_FFFD, hiObs, loObs, dzObs, edgeObs, tOk);
        @(negedge clock);
        op    = 1'b1;
        a     = 32'd1000;
        b     = 32'd3;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        #2 clear = 1'b1;
        #1;
        checks++;
        if ({busy, done, hi_lo_write, div_zero, hi_out, lo_out} !== 68'd0) begin
            errors++;
            $display("[TB] FAIL clear_async got %h expected 0", {busy, done, hi_lo_write, div_zero, hi_out, lo_out});
        end
        @(negedge clock);
        checks++;
        if ({busy, done, hi_out, lo_out} !== 66'd0) begin
            errors++;
            $display("[TB] FAIL clear_held got %h expected 0", {busy, done, hi_out, lo_out});
        end
        clear = 1'b0;
        x   = $urandom;
        y   = ($urandom >> 4) + 32'd1;
        exp = refMdu(1'b1, x, y);
        doOp(1'b1, x, y, hiObs, loObs, dzObs, edgeObs, tOk);
        checks++;
        if ({dzObs, hiObs, loObs} !== exp || edgeObs !== 33 || tOk !== 1'b1) begin
            errors++;
            $display("[TB] FAIL after_clear got %h@%0d expected %h@33", {dzObs, hiObs, loObs}, edgeObs, exp);
        end
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_div_zero();
        test_back_to_back();
        test_clear_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
